// File: rtl/mii_preamble_regen_pkg.sv
// Shared constants and types for the MII transmit preamble regenerator.
package mii_preamble_regen_pkg;

    typedef logic [3:0] nibble_t;

    localparam nibble_t PRE_NIBBLE  = 4'h5;
    localparam nibble_t SFD_NIBBLE  = 4'hD;
    localparam int      PRE_DEFAULT = 15;
    localparam int      IPG_DEFAULT = 24;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR  = 3'd3,
        ST_IPG  = 3'd4
    } state_t;

    typedef struct packed {
        logic    en;
        logic    er;
        nibble_t d;
    } tx_nib_t;

    localparam tx_nib_t NIB_IDLE = '{en: 1'b0, er: 1'b0, d: 4'h0};
    localparam tx_nib_t NIB_ERR  = '{en: 1'b1, er: 1'b1, d: 4'h0};
    localparam tx_nib_t NIB_PRE  = '{en: 1'b1, er: 1'b0, d: PRE_NIBBLE};
    localparam tx_nib_t NIB_SFD  = '{en: 1'b1, er: 1'b0, d: SFD_NIBBLE};

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mii_preamble_regen_if.sv
// Elastic-buffer pull side and MII transmit side of the preamble regenerator.
interface mii_preamble_regen_if;
    import mii_preamble_regen_pkg::*;

    logic    buf_ce;
    logic    buf_dv;
    logic    buf_er;
    nibble_t buf_d;
    logic    tx_en;
    logic    tx_er;
    nibble_t txd;
    logic    frame_err;

    modport master (
        input  buf_ce, tx_en, tx_er, txd, frame_err,
        output buf_dv, buf_er, buf_d
    );

    modport slave (
        output buf_ce, tx_en, tx_er, txd, frame_err,
        input  buf_dv, buf_er, buf_d
    );

endinterface

// File: rtl/mii_preamble_regen.sv
// Pulls nibbles from the elastic buffer, regenerates a full preamble before
// each SFD, enforces the inter-packet gap and error-marks bad preambles.
//
// state    | meaning
// ST_IDLE  | waiting for a good nibble; false carrier is dropped
// ST_PRE   | emitting preamble, stalling the buffer on an early SFD
// ST_DATA  | forwarding frame nibbles (buffer errors pass through as tx_er)
// ST_ERR   | malformed preamble: every remaining nibble sent as an error
// ST_IPG   | idle gap; buffer held until the gap count completes
module mii_preamble_regen
    import mii_preamble_regen_pkg::*;
#(
    parameter int PRE_LEN = PRE_DEFAULT,
    parameter int IPG_LEN = IPG_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    mii_preamble_regen_if.slave bus
);

    localparam int CNT_W = $clog2(max_int(PRE_LEN, IPG_LEN) + 1);
    localparam logic [CNT_W-1:0] PRE_TC  = CNT_W'(PRE_LEN);
    localparam logic [CNT_W-1:0] IPG_TC  = CNT_W'(IPG_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    tx_nib_t          tx_q, tx_d;
    logic             frame_err_q, frame_err_d;
    logic             pull;

    logic good, good_pre, good_sfd, pre_full;

    assign good     = bus.buf_dv && !bus.buf_er;
    assign good_pre = good && (bus.buf_d == PRE_NIBBLE);
    assign good_sfd = good && (bus.buf_d == SFD_NIBBLE);
    assign pre_full = (cnt_q >= PRE_TC);
    assign cnt_inc  = cnt_q + CNT_ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            tx_q        <= NIB_IDLE;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tx_q        <= tx_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (ce) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (good) begin
                        state_d = ST_PRE;
                        cnt_d   = CNT_ONE;
                    end
                end
                ST_PRE: begin
                    if (good_pre) begin
                        if (!pre_full) cnt_d = cnt_inc;
                    end else if (good_sfd) begin
                        if (!pre_full) cnt_d = cnt_inc;
                        else           state_d = ST_DATA;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
                ST_DATA, ST_ERR: begin
                    if (!bus.buf_dv) begin
                        state_d = ST_IPG;
                        cnt_d   = CNT_ONE;
                    end
                end
                ST_IPG: begin
                    // The idle nibble that closed the frame counts as gap nibble 1.
                    if (cnt_inc == IPG_TC) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_inc;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        pull        = 1'b0;
        tx_d        = tx_q;
        frame_err_d = 1'b0;
        if (ce) begin
            unique case (state_q)
                ST_IDLE: begin
                    // A good non-5 nibble is left in the buffer for the preamble logic.
                    pull = !(good && !good_pre);
                    tx_d = good ? NIB_PRE : NIB_IDLE;
                end
                ST_PRE: begin
                    if (good_pre) begin
                        pull = 1'b1;
                        tx_d = NIB_PRE;
                    end else if (good_sfd) begin
                        pull = pre_full;
                        tx_d = pre_full ? NIB_SFD : NIB_PRE;
                    end else begin
                        pull        = 1'b1;
                        tx_d        = NIB_ERR;
                        frame_err_d = 1'b1;
                    end
                end
                ST_DATA: begin
                    pull = 1'b1;
                    tx_d = bus.buf_dv ? tx_nib_t'{en: 1'b1, er: bus.buf_er, d: bus.buf_d}
                                      : NIB_IDLE;
                end
                ST_ERR: begin
                    pull = 1'b1;
                    tx_d = bus.buf_dv ? NIB_ERR : NIB_IDLE;
                end
                ST_IPG: begin
                    pull = 1'b0;
                    tx_d = NIB_IDLE;
                end
                default: begin
                    pull = 1'b0;
                    tx_d = NIB_IDLE;
                end
            endcase
        end
    end

    assign bus.buf_ce    = ce && pull && !rst;
    assign bus.tx_en     = tx_q.en;
    assign bus.tx_er     = tx_q.er;
    assign bus.txd       = tx_q.d;
    assign bus.frame_err = frame_err_q;

endmodule
